// File: rtl/collider_pkg.sv
// Shared types and screen geometry for the terrain probe scheduler.
package collider_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        ARMED,
        SERVE
    } probe_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    int          p;
    logic [PW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        p     = 0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            p = int'(ptr) + k;
            if (p >= N) begin
                p = p - N;
            end
            pos = PW'(p);
            if (!any && mask[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/terrain_probe_scheduler.sv
// Shares one terrain-column sampler between N_REQ collision requesters; probes are
// snapshotted at frame start and answered one per cycle when their column passes.
module terrain_probe_scheduler #(
    parameter int N_REQ    = 4,
    parameter int SCREEN_W = collider_pkg::SCREEN_W,
    parameter int SCREEN_H = collider_pkg::SCREEN_H
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic                  col_valid,
    input  logic [9:0]            DrawX,
    input  logic [SCREEN_H-1:0]   terrain_data,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*10-1:0]   req_x,
    input  logic [N_REQ*10-1:0]   req_y,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      hit,
    output logic                  busy
);

    import collider_pkg::*;

    localparam int     PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int     YW    = $clog2(SCREEN_H);
    localparam coord_t X_LIM = coord_t'(SCREEN_W);
    localparam coord_t Y_LIM = coord_t'(SCREEN_H);

    probe_state_t        state_q, state_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [N_REQ-1:0]    match_q, match_d;
    logic [N_REQ-1:0]    oob_q, oob_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    hit_q, hit_d;
    coord_t              x_q [N_REQ];
    coord_t              x_d [N_REQ];
    coord_t              y_q [N_REQ];
    coord_t              y_d [N_REQ];
    logic [SCREEN_H-1:0] col_buf_q, col_buf_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                defer_q, defer_d;

    coord_t              in_x [N_REQ];
    coord_t              in_y [N_REQ];
    logic [N_REQ-1:0]    req_live;
    logic [N_REQ-1:0]    new_entry;
    logic [N_REQ-1:0]    oob_vec;
    logic [N_REQ-1:0]    col_eq;

    // A requester still holding req in its ack cycle is finishing the old probe, not posting a new one.
    assign req_live = req & ~ack_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_entry
            coord_t x_sel;
            coord_t y_sel;
            assign in_x[gi]      = req_x[10*gi +: 10];
            assign in_y[gi]      = req_y[10*gi +: 10];
            assign new_entry[gi] = req_live[gi] & ~pending_q[gi];
            assign x_sel         = new_entry[gi] ? in_x[gi] : x_q[gi];
            assign y_sel         = new_entry[gi] ? in_y[gi] : y_q[gi];
            assign oob_vec[gi]   = (x_sel >= X_LIM) | (y_sel >= Y_LIM);
            assign col_eq[gi]    = (x_q[gi] == DrawX);
        end
    endgenerate

    logic [N_REQ-1:0] serve_mask;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx;
    logic             grant_any;

    // Cancelled entries drop out of the serve set the same cycle they lose req.
    assign serve_mask = match_q & req;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .mask  (serve_mask),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    coord_t        grant_y;
    logic          grant_y_ok;
    logic [YW-1:0] grant_y_idx;
    logic          col_bit;

    assign grant_y     = y_q[grant_idx];
    assign grant_y_ok  = grant_y < Y_LIM;
    assign grant_y_idx = grant_y[YW-1:0];
    assign col_bit     = grant_y_ok ? col_buf_q[grant_y_idx] : 1'b0;

    logic [N_REQ-1:0] snap_pend;
    logic [N_REQ-1:0] snap_oob;
    logic [N_REQ-1:0] col_match;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q & req;
        match_d   = match_q & req;
        oob_d     = oob_q;
        x_d       = x_q;
        y_d       = y_q;
        col_buf_d = col_buf_q;
        rr_ptr_d  = rr_ptr_q;
        defer_d   = defer_q;
        ack_d     = '0;
        hit_d     = '0;
        snap_pend = (pending_q & req) | req_live;
        snap_oob  = snap_pend & oob_vec;
        col_match = pending_q & req & col_eq;

        case (state_q)
            IDLE: begin
                if (frame_start || defer_q) begin
                    state_d = SNAP;
                    defer_d = 1'b0;
                end
            end

            SNAP: begin
                defer_d   = defer_q | frame_start;
                pending_d = snap_pend;
                for (int i = 0; i < N_REQ; i++) begin
                    if (new_entry[i]) begin
                        x_d[i] = in_x[i];
                        y_d[i] = in_y[i];
                    end
                end
                if (snap_pend == '0) begin
                    state_d = IDLE;
                end else if (snap_oob != '0) begin
                    match_d = snap_oob;
                    oob_d   = snap_oob;
                    state_d = SERVE;
                end else begin
                    oob_d   = '0;
                    state_d = ARMED;
                end
            end

            ARMED: begin
                // A column and a frame pulse in the same cycle: take the column, remember the frame.
                if (col_valid && (col_match != '0)) begin
                    match_d   = col_match;
                    oob_d     = '0;
                    col_buf_d = terrain_data;
                    defer_d   = defer_q | frame_start;
                    state_d   = SERVE;
                end else if (frame_start || defer_q) begin
                    defer_d = 1'b0;
                    state_d = SNAP;
                end else if (pending_d == '0) begin
                    state_d = IDLE;
                end
            end

            SERVE: begin
                defer_d   = defer_q | frame_start;
                match_d   = serve_mask & ~grant;
                pending_d = pending_q & req & ~grant;
                if (grant_any) begin
                    ack_d    = grant;
                    hit_d    = grant & {N_REQ{oob_q[grant_idx] | col_bit}};
                    rr_ptr_d = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
                if (match_d == '0) begin
                    if (defer_d) begin
                        defer_d = 1'b0;
                        state_d = SNAP;
                    end else if (pending_d == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            match_q   <= '0;
            oob_q     <= '0;
            ack_q     <= '0;
            hit_q     <= '0;
            col_buf_q <= '0;
            rr_ptr_q  <= '0;
            defer_q   <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            match_q   <= match_d;
            oob_q     <= oob_d;
            ack_q     <= ack_d;
            hit_q     <= hit_d;
            col_buf_q <= col_buf_d;
            rr_ptr_q  <= rr_ptr_d;
            defer_q   <= defer_d;
            for (int i = 0; i < N_REQ; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign ack  = ack_q;
    assign hit  = hit_q;
    assign busy = (state_q != IDLE);

endmodule
